// File: rtl/mem_pkg.sv
// Shared types and constants for the data memory responder.
package mem_pkg;

  localparam int DATA_W = 32;
  // Wide enough for LATENCY-1 with LATENCY up to 15.
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/ram_word_array.sv
// Word-addressed storage: one synchronous write port, one combinational read port.
module ram_word_array
  import mem_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Guard keeps non-power-of-two depths from reading past the array.
  assign rdata = (32'(raddr) < 32'(DEPTH)) ? mem[raddr] : '0;

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding load/store responder with a fixed wait latency and
// alignment/range fault detection in front of a word array.
module data_mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [31:0]        addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic               rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;

  logic               accept;
  logic               eff_we;
  logic [31:0]        eff_addr;
  logic [DATA_W-1:0]  eff_wdata;
  logic               fault;
  logic               ram_we;
  logic [DATA_W-1:0]  ram_rdata;

  assign accept = req_valid && (state_q == IDLE);

  // With LATENCY=0 the RESP-entry edge is the acceptance edge, so the live
  // request fields stand in for the not-yet-latched ones.
  assign eff_we    = accept ? req_we    : we_q;
  assign eff_addr  = accept ? req_addr  : addr_q;
  assign eff_wdata = accept ? req_wdata : wdata_q;

  assign fault = (eff_addr[1:0] != 2'b00) ||
                 ({2'b00, eff_addr[31:2]} >= 32'(DEPTH));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    ram_we      = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (LATENCY == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // RESP always exits to IDLE, so state_d==RESP marks the entry edge.
    if (state_d == RESP) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = fault;
      ram_we      = eff_we && !fault;
      if (!eff_we && !fault) begin
        rsp_rdata_d = ram_rdata;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  ram_word_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (eff_addr[AW+1:2]),
    .wdata (eff_wdata),
    .raddr (eff_addr[AW+1:2]),
    .rdata (ram_rdata)
  );

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: one LATENCY=2 and one LATENCY=0 instance.
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        a_valid, a_we, a_ready, a_rsp_valid, a_err;
  logic [31:0] a_addr, a_wdata, a_rdata;
  logic        b_valid, b_we, b_ready, b_rsp_valid, b_err;
  logic [31:0] b_addr, b_wdata, b_rdata;

  data_mem_responder #(.DEPTH(64), .LATENCY(2)) dut_a (
    .clk(clk), .reset(reset),
    .req_valid(a_valid), .req_we(a_we), .req_addr(a_addr), .req_wdata(a_wdata),
    .req_ready(a_ready), .rsp_valid(a_rsp_valid), .rsp_rdata(a_rdata), .rsp_err(a_err)
  );

  data_mem_responder #(.DEPTH(64), .LATENCY(0)) dut_b (
    .clk(clk), .reset(reset),
    .req_valid(b_valid), .req_we(b_we), .req_addr(b_addr), .req_wdata(b_wdata),
    .req_ready(b_ready), .rsp_valid(b_rsp_valid), .rsp_rdata(b_rdata), .rsp_err(b_err)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  logic [31:0] model_a [64];
  logic [31:0] model_b [64];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Response monitors: pop the scoreboard on every rsp_valid, check quiet outputs otherwise.
  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if (a_rsp_valid) begin
        if (qa.size() == 0) begin
          errors++;
          $display("FAIL a_unexpected_rsp: rsp_valid=1 at cycle %0d, required no response", cyc);
        end else begin
          ea = qa.pop_front();
          $display("A rsp cycle %0d: rdata=%h err=%0b latency=%0d", cyc, a_rdata, a_err, cyc - ea.acc);
          if (a_rdata !== ea.rdata || a_err !== ea.err || (cyc - ea.acc) != 3) begin
            errors++;
            $display("FAIL a_rsp: rdata=%h err=%0b latency=%0d, required rdata=%h err=%0b latency=3",
                     a_rdata, a_err, cyc - ea.acc, ea.rdata, ea.err);
          end
        end
      end else if (a_rdata !== 32'h0 || a_err !== 1'b0) begin
        errors++;
        $display("FAIL a_idle_outputs: rdata=%h err=%0b, required 0/0", a_rdata, a_err);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if (b_rsp_valid) begin
        if (qb.size() == 0) begin
          errors++;
          $display("FAIL b_unexpected_rsp: rsp_valid=1 at cycle %0d, required no response", cyc);
        end else begin
          eb = qb.pop_front();
          $display("B rsp cycle %0d: rdata=%h err=%0b latency=%0d", cyc, b_rdata, b_err, cyc - eb.acc);
          if (b_rdata !== eb.rdata || b_err !== eb.err || (cyc - eb.acc) != 1) begin
            errors++;
            $display("FAIL b_rsp: rdata=%h err=%0b latency=%0d, required rdata=%h err=%0b latency=1",
                     b_rdata, b_err, cyc - eb.acc, eb.rdata, eb.err);
          end
        end
      end else if (b_rdata !== 32'h0 || b_err !== 1'b0) begin
        errors++;
        $display("FAIL b_idle_outputs: rdata=%h err=%0b, required 0/0", b_rdata, b_err);
      end
    end
  end

  function automatic exp_t predict(input bit sel, input bit we, input logic [31:0] addr,
                                   input logic [31:0] wdata);
    exp_t e;
    int   idx;
    e.err   = (addr[1:0] != 2'b00) || (addr[31:2] >= 30'd64);
    e.rdata = 32'h0;
    e.acc   = 0;
    idx     = int'(addr[7:2]);
    if (!e.err) begin
      if (we) begin
        if (sel) model_b[idx] = wdata;
        else     model_a[idx] = wdata;
      end else begin
        e.rdata = sel ? model_b[idx] : model_a[idx];
      end
    end
    return e;
  endfunction

  task automatic drive(input bit sel, input bit v, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata);
    if (sel) begin b_valid = v; b_we = we; b_addr = addr; b_wdata = wdata; end
    else     begin a_valid = v; a_we = we; a_addr = addr; a_wdata = wdata; end
  endtask

  // Issue one request; optionally scramble the request inputs right after acceptance.
  task automatic xact(input bit sel, input bit we, input logic [31:0] addr,
                      input logic [31:0] wdata, input bit perturb);
    exp_t e;
    bit   got;
    e = predict(sel, we, addr, wdata);
    drive(sel, 1'b1, we, addr, wdata);
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (sel ? b_ready : a_ready) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL accept_timeout: req_ready=0 for 40 cycles, required 1");
    end else begin
      e.acc = cyc;
      if (sel) qb.push_back(e);
      else     qa.push_back(e);
    end
    @(posedge clk); #1;
    if (perturb) drive(sel, 1'b0, 1'b1, 32'h20, 32'hFFFF_FFFF);
    else         drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic drain;
    for (int i = 0; i < 30 && (qa.size() != 0 || qb.size() != 0); i++) @(negedge clk);
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d/%0d responses outstanding, required 0/0", qa.size(), qb.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    checks++;
    if ({a_ready, a_rsp_valid, a_err, a_rdata} !== {3'b100, 32'h0}) begin
      errors++;
      $display("FAIL reset_a: ready/valid/err/rdata=%b/%b/%b/%h, required 1/0/0/0",
               a_ready, a_rsp_valid, a_err, a_rdata);
    end
    checks++;
    if ({b_ready, b_rsp_valid, b_err, b_rdata} !== {3'b100, 32'h0}) begin
      errors++;
      $display("FAIL reset_b: ready/valid/err/rdata=%b/%b/%b/%h, required 1/0/0/0",
               b_ready, b_rsp_valid, b_err, b_rdata);
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_store_load;
    xact(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0);
    xact(1'b0, 1'b0, 32'h10, 32'h0, 1'b0);
    drain();
  endtask

  task automatic test_faults;
    xact(1'b0, 1'b1, 32'h00, 32'h1111_1111, 1'b0);
    xact(1'b0, 1'b1, 32'hFC, 32'h6363_6363, 1'b0);
    xact(1'b0, 1'b0, 32'h13, 32'h0, 1'b0);
    xact(1'b0, 1'b0, 32'h100, 32'h0, 1'b0);
    xact(1'b0, 1'b1, 32'h100, 32'hBAD0_BAD0, 1'b0);
    xact(1'b0, 1'b1, 32'h12, 32'hBAD1_BAD1, 1'b0);
    xact(1'b0, 1'b0, 32'h00, 32'h0, 1'b0);
    xact(1'b0, 1'b0, 32'hFC, 32'h0, 1'b0);
    xact(1'b0, 1'b0, 32'h10, 32'h0, 1'b0);
    drain();
  endtask

  task automatic test_back_to_back;
    int   acc[$];
    exp_t e;
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (a_ready) begin
        e = predict(1'b0, 1'b0, 32'h10, 32'h0);
        e.acc = cyc;
        qa.push_back(e);
        acc.push_back(cyc);
      end
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checks++;
    if (acc.size() < 3) begin
      errors++;
      $display("FAIL b2b_count: %0d acceptances in 14 cycles, required at least 3", acc.size());
    end
    for (int i = 1; i < acc.size(); i++) begin
      checks++;
      if (acc[i] - acc[i-1] != 4) begin
        errors++;
        $display("FAIL b2b_spacing: acceptance gap %0d cycles, required 4", acc[i] - acc[i-1]);
      end
    end
    drain();
  endtask

  task automatic test_latency0;
    xact(1'b1, 1'b1, 32'h4, 32'h1, 1'b0);
    xact(1'b1, 1'b0, 32'h4, 32'h0, 1'b0);
    xact(1'b1, 1'b0, 32'h6, 32'h0, 1'b0);
    drain();
  endtask

  task automatic test_reset_abort;
    bit got;
    xact(1'b0, 1'b1, 32'h8, 32'h0000_0011, 1'b0);
    drain();
    drive(1'b0, 1'b1, 1'b1, 32'h8, 32'h0000_0055);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (a_ready) got = 1'b1;
    end
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    #2;
    checks++;
    if (!got || a_ready !== 1'b1 || a_rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_reset: accepted=%0b ready=%b rsp_valid=%b, required 1/1/0",
               got, a_ready, a_rsp_valid);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    xact(1'b0, 1'b0, 32'h8, 32'h0, 1'b0);
    drain();
  endtask

  task automatic test_addr_change;
    xact(1'b0, 1'b1, 32'h20, 32'h2020_2020, 1'b0);
    xact(1'b0, 1'b0, 32'h10, 32'h0, 1'b1);
    drain();
    xact(1'b0, 1'b0, 32'h20, 32'h0, 1'b0);
    drain();
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_faults();
    test_back_to_back();
    test_latency0();
    test_reset_abort();
    test_addr_change();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 64, meaning the number of 32-bit words stored.
REQ-002 The block SHALL have parameter LATENCY, default 2, meaning the wait cycles between request acceptance and response; the legal range is 0..15.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port req_valid, input, 1 bit: the initiator presents a request.
REQ-006 The block SHALL have port req_we, input, 1 bit: 1 means store, 0 means load.
REQ-007 The block SHALL have port req_addr, input, 32 bits: the byte address.
REQ-008 The block SHALL have port req_wdata, input, 32 bits: the store data.
REQ-009 The block SHALL have port req_ready, output, 1 bit: the responder can accept a request.
REQ-010 The block SHALL have port rsp_valid, output, 1 bit: a one-cycle response pulse.
REQ-011 The block SHALL have port rsp_rdata, output, 32 bits: the load data, qualified by rsp_valid.
REQ-012 The block SHALL have port rsp_err, output, 1 bit: the access fault flag, qualified by rsp_valid.

Function
REQ-013 The FSM SHALL have the states IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-014 A request SHALL be accepted on an edge where req_valid=1 and req_ready=1.
- On acceptance, req_we, req_addr and req_wdata SHALL be latched.
- Later input changes SHALL be ignored until the next acceptance.
REQ-015 On acceptance, the next state SHALL be WAIT with the counter loaded to LATENCY-1 when LATENCY>0, or RESP when LATENCY=0.
REQ-016 In WAIT the counter SHALL decrement each cycle, and the FSM SHALL move to RESP on the edge where the counter equals 0.
REQ-017 RESP SHALL last exactly one cycle with rsp_valid=1, then return to IDLE; the response therefore appears LATENCY+1 cycles after acceptance.
REQ-018 Word index = addr[31:2]. A fault SHALL be signalled when addr[1:0]!=0 or word index>=DEPTH.
REQ-019 For a non-faulting store, the array write SHALL occur on the edge entering RESP; rsp_rdata SHALL be 0 in RESP.
REQ-020 For a non-faulting load, rsp_rdata SHALL equal the array word at the latched index, including a store completed in the immediately preceding transaction.
REQ-021 For a faulting access: rsp_err=1 in RESP, no array write, rsp_rdata=0.
REQ-022 Outside RESP, the outputs SHALL be rsp_valid=0, rsp_err=0 and rsp_rdata=0.
REQ-023 A req_valid asserted during WAIT or RESP SHALL NOT be accepted; acceptance is possible no earlier than the cycle after RESP.
REQ-024 There SHALL be no response backpressure: the initiator must sample the response in the RESP cycle.

Reset
REQ-025 reset=1 SHALL immediately force IDLE, counter=0, all latched request fields=0, req_ready=1, rsp_valid=0, rsp_err=0 and rsp_rdata=0.
REQ-026 Reset asserted mid-transaction SHALL abort the transaction with no response; a store aborted before entering RESP SHALL NOT modify the array.
REQ-027 Array contents SHALL be unaffected by reset.

Structure
REQ-028 Package mem_pkg SHALL hold the state enum (IDLE/WAIT/RESP), DATA_W=32 and the counter width constant.
REQ-029 The storage SHALL be the sub-module ram_word_array, with one synchronous write port and one combinational read port, parameterized by DEPTH.
REQ-030 The FSM, counter, latches and fault check SHALL be in data_mem_responder.

Verification
REQ-031 Store addr 0x10, wdata 0xDEADBEEF, then load addr 0x10 (LATENCY=2) -> each rsp_valid occurs 3 cycles after acceptance; load rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-032 Load addr 0x13 -> rsp_err=1, rsp_rdata=0; load 0x100 (word 64, DEPTH=64) -> rsp_err=1; store 0x100 -> word 0 and word 63 unchanged.
REQ-033 req_valid held high continuously with LATENCY=2 -> one acceptance every 4 cycles; req_ready=0 in WAIT and RESP.
REQ-034 LATENCY=0 build: store 0x4 value 0x1 then load 0x4 -> rsp_valid 1 cycle after each acceptance; load returns 0x1.
REQ-035 Reset pulse 1 cycle after accepting store 0x8 value 0x55 -> no rsp_valid, req_ready=1 after reset; a subsequent load 0x8 returns the prior contents, not 0x55.
REQ-036 Change req_addr and req_wdata during WAIT of a load of 0x10 -> response reflects the latched address 0x10.
